// File: rtl/kv_lookup_responder.sv
// kv_lookup_responder: database-side key table responder.
// This block takes one key operation per cycle and returns its result exactly two cycles later.
// The operation is lookup, insert or delete. The key table is direct-mapped and indexed by an
// XOR-fold hash of the key.
// Optional build macro: KV_HIT_COUNTER_EN enables the saturating stat_hits counter.
// When the macro is undefined, stat_hits is tied to zero.
module kv_lookup_responder #(
    parameter int unsigned KEY_SIZE   = 96,
    parameter int unsigned FLAG_WIDTH = 4,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KEY_SIZE-1:0]   in_key,
    input  logic [FLAG_WIDTH-1:0] in_flag,
    input  logic                  in_valid,
    output logic                  out_valid,
    output logic [FLAG_WIDTH-1:0] out_flag,
    output logic [31:0]           stat_hits
);

    localparam int unsigned N_CHUNK = (KEY_SIZE + IDX_W - 1) / IDX_W;
    localparam int unsigned PAD_W   = N_CHUNK * IDX_W;
    localparam int unsigned DEPTH   = 1 << IDX_W;

    localparam logic [FLAG_WIDTH-1:0] OP_LOOKUP = FLAG_WIDTH'(4'b0001);
    localparam logic [FLAG_WIDTH-1:0] OP_INSERT = FLAG_WIDTH'(4'b0010);
    localparam logic [FLAG_WIDTH-1:0] OP_DELETE = FLAG_WIDTH'(4'b0100);

    // Result codes: bit0 present-before, bit1 success, bit2 collision, bit3 illegal
    localparam logic [FLAG_WIDTH-1:0] RES_MISS    = FLAG_WIDTH'(4'b0000);
    localparam logic [FLAG_WIDTH-1:0] RES_HIT     = FLAG_WIDTH'(4'b0011);
    localparam logic [FLAG_WIDTH-1:0] RES_INS_OK  = FLAG_WIDTH'(4'b0010);
    localparam logic [FLAG_WIDTH-1:0] RES_COLLIDE = FLAG_WIDTH'(4'b0100);
    localparam logic [FLAG_WIDTH-1:0] RES_ILLEGAL = FLAG_WIDTH'(4'b1000);

    // Hash and S1 pipeline signals
    logic [PAD_W-1:0]      key_pad_c;
    logic [IDX_W-1:0]      idx_c;

    logic                  s1_valid_q, s1_valid_d;
    logic [KEY_SIZE-1:0]   s1_key_q,   s1_key_d;
    logic [FLAG_WIDTH-1:0] s1_op_q,    s1_op_d;
    logic [IDX_W-1:0]      s1_idx_q,   s1_idx_d;

    // Table storage: valid bits are reset, key storage is not
    logic [DEPTH-1:0]      tbl_vld_q,  tbl_vld_d;
    logic [KEY_SIZE-1:0]   tbl_key_q [DEPTH];
    logic                  key_we_c;

    // S2 signals and output registers
    logic                  ent_vld_c;
    logic                  present_c;
    logic [FLAG_WIDTH-1:0] res_c;

    logic                  out_valid_q, out_valid_d;
    logic [FLAG_WIDTH-1:0] out_flag_q,  out_flag_d;

    // XOR-fold the zero-padded key into an IDX_W-bit table index
    always_comb begin
        key_pad_c = PAD_W'(in_key);
        idx_c     = '0;
        for (int unsigned i = 0; i < N_CHUNK; i++) begin
            idx_c = idx_c ^ key_pad_c[i*IDX_W +: IDX_W];
        end
    end

    // S1 capture; payload holds its value when no request is offered
    always_comb begin
        s1_valid_d = in_valid;
        s1_key_d   = s1_key_q;
        s1_op_d    = s1_op_q;
        s1_idx_d   = s1_idx_q;
        if (in_valid) begin
            s1_key_d = in_key;
            s1_op_d  = in_flag;
            s1_idx_d = idx_c;
        end
    end

    // S1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_key_q   <= '0;
            s1_op_q    <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_key_q   <= s1_key_d;
            s1_op_q    <= s1_op_d;
            s1_idx_q   <= s1_idx_d;
        end
    end

    // S2: read the entry, compare the keys, decide the result and the table write
    always_comb begin
        ent_vld_c   = tbl_vld_q[s1_idx_q];
        present_c   = ent_vld_c && (tbl_key_q[s1_idx_q] == s1_key_q);
        res_c       = RES_MISS;
        tbl_vld_d   = tbl_vld_q;
        key_we_c    = 1'b0;
        if (s1_valid_q) begin
            case (s1_op_q)
                OP_LOOKUP: begin
                    res_c = present_c ? RES_HIT : RES_MISS;
                end
                OP_INSERT: begin
                    if (present_c) begin
                        res_c = RES_HIT;
                    end else if (!ent_vld_c) begin
                        res_c               = RES_INS_OK;
                        key_we_c            = 1'b1;
                        tbl_vld_d[s1_idx_q] = 1'b1;
                    end else begin
                        res_c = RES_COLLIDE;
                    end
                end
                OP_DELETE: begin
                    if (present_c) begin
                        res_c               = RES_HIT;
                        tbl_vld_d[s1_idx_q] = 1'b0;
                    end
                end
                default: begin
                    res_c = RES_ILLEGAL;
                end
            endcase
        end
    end

    // Output next state: out_flag holds its last value across idle cycles
    always_comb begin
        out_valid_d = s1_valid_q;
        out_flag_d  = s1_valid_q ? res_c : out_flag_q;
    end

    // Table valid bits and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld_q   <= '0;
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
        end else begin
            tbl_vld_q   <= tbl_vld_d;
            out_valid_q <= out_valid_d;
            out_flag_q  <= out_flag_d;
        end
    end

    // Key storage write port (no reset needed: guarded by the valid bits)
    always_ff @(posedge clk) begin
        if (key_we_c) begin
            tbl_key_q[s1_idx_q] <= s1_key_q;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flag  = out_flag_q;

`ifdef KV_HIT_COUNTER_EN
    logic [31:0] hits_q, hits_d;

    // Saturating count of results reporting the key present before the op
    always_comb begin
        hits_d = hits_q;
        if (s1_valid_q && res_c[0] && (hits_q != 32'hFFFF_FFFF)) begin
            hits_d = hits_q + 32'd1;
        end
    end

    // Hit counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q <= 32'd0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign stat_hits = hits_q;
`else
    assign stat_hits = 32'd0;
`endif

endmodule
